// File: rtl/mio_pkg.sv
// Shared types and address constants for the memory/IO bus controller.
package mio_pkg;

  // Bus FSM states.
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  // Decoded access target.
  typedef enum logic [2:0] {
    T_RAM,
    T_SEG,
    T_GPIO,
    T_CNT,
    T_NONE
  } target_e;

  // Fixed peripheral byte addresses.
  localparam logic [31:0] SEG_ADDR  = 32'hE000_0000;
  localparam logic [31:0] GPIO_ADDR = 32'hF000_0000;
  localparam logic [31:0] CNT_ADDR  = 32'hF000_0004;

endpackage

// File: rtl/mio_addr_decode.sv
// Combinational address decoder: word address -> access target.
module mio_addr_decode
  import mio_pkg::*;
#(
  parameter int RAM_ADDR_W = 10
) (
  input  logic [29:0] word_addr_i,  // byte address bits [31:2]
  output target_e     target_o
);

  // Full compare on the word address; RAM occupies the bottom 2^RAM_ADDR_W words.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    target_o = T_NONE;
    if ((word_addr_i >> RAM_ADDR_W) == 30'd0) begin
      target_o = T_RAM;
    end else if (word_addr_i == SEG_ADDR[31:2]) begin
      target_o = T_SEG;
    end else if (word_addr_i == GPIO_ADDR[31:2]) begin
      target_o = T_GPIO;
    end else if (word_addr_i == CNT_ADDR[31:2]) begin
      target_o = T_CNT;
    end
  end

endmodule

// File: rtl/mio_bus_ctrl.sv
// Memory/IO bus controller: decodes CPU accesses to RAM, GPIO, 7-seg and a
// free-running counter, and answers every accepted access with one MIO_ready.
module mio_bus_ctrl
  import mio_pkg::*;
#(
  parameter int RAM_ADDR_W = 10,
  parameter int RAM_WAIT   = 1,   // 1..7
  parameter int CNT_W      = 32   // <= 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_r,
  input  logic                  mem_w,
  input  logic [31:0]           addr_in,
  input  logic [31:0]           wdata_in,
  output logic [31:0]           rdata_out,
  output logic                  MIO_ready,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic [31:0]           ram_din,
  output logic                  ram_we,
  input  logic [31:0]           ram_dout,
  input  logic [15:0]           sw,
  input  logic [3:0]            btn,
  output logic [15:0]           led_out,
  output logic [31:0]           seg_out,
  output logic [CNT_W-1:0]      cnt_out,
  output logic                  bus_err
);

  localparam logic [2:0] WAIT_INIT = 3'(RAM_WAIT - 1);

  state_e                state_q, state_d;
  target_e               dec_tgt, tgt_q;
  logic                  wr_q;
  logic [RAM_ADDR_W-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [2:0]            wcnt_q;
  logic [31:0]           rdata_q;
  logic [15:0]           led_q;
  logic [31:0]           seg_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  err_q;
  logic                  accept;
  logic [31:0]           reg_rdata;

  mio_addr_decode #(
    .RAM_ADDR_W (RAM_ADDR_W)
  ) u_decode (
    .word_addr_i (addr_in[31:2]),
    .target_o    (dec_tgt)
  );

  // A request is taken only from IDLE with exactly one of read/write high.
  assign accept = (state_q == IDLE) && (mem_r ^ mem_w);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking for all clocked state so every register sees pre-edge values.
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: RAM reads detour through WAIT, everything else answers next cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = (mem_r && (dec_tgt == T_RAM)) ? WAIT : RESP;
      WAIT: if (wcnt_q == 3'd0) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Register read mux, sampled on the accept edge.
  always_comb begin
    reg_rdata = 32'd0;
    case (dec_tgt)
      T_SEG:   reg_rdata = seg_q;
      T_GPIO:  reg_rdata = {btn, 12'd0, sw};
      T_CNT:   reg_rdata = 32'(cnt_q);
      default: reg_rdata = 32'd0;
    endcase
  end

  // Latches, peripheral registers, counter and read data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tgt_q   <= T_NONE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      wcnt_q  <= 3'd0;
      rdata_q <= 32'd0;
      led_q   <= 16'd0;
      seg_q   <= 32'd0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
      if (accept) begin
        addr_q  <= addr_in[RAM_ADDR_W+1:2];
        wdata_q <= wdata_in;
        tgt_q   <= dec_tgt;
        wr_q    <= mem_w;
        wcnt_q  <= WAIT_INIT;
        if (dec_tgt == T_NONE) err_q <= 1'b1;
        if (mem_w) begin
          // A counter load overrides the increment scheduled above.
          case (dec_tgt)
            T_SEG:   seg_q <= wdata_in;
            T_GPIO:  led_q <= wdata_in[15:0];
            T_CNT:   cnt_q <= wdata_in[CNT_W-1:0];
            default: ;
          endcase
        end else if (dec_tgt != T_RAM) begin
          rdata_q <= reg_rdata;
        end
      end else if (state_q == WAIT) begin
        if (wcnt_q == 3'd0) rdata_q <= ram_dout;
        else                wcnt_q  <= wcnt_q - 3'd1;
      end
    end
  end

  // Bus outputs; RAM sees the live address in IDLE so its data is ready by the end of WAIT.
  always_comb begin
    MIO_ready = (state_q == RESP);
    ram_we    = (state_q == RESP) && wr_q && (tgt_q == T_RAM) && reset;
    ram_addr  = (state_q == IDLE) ? addr_in[RAM_ADDR_W+1:2] : addr_q;
    ram_din   = wdata_q;
  end

  assign rdata_out = rdata_q;
  assign led_out   = led_q;
  assign seg_out   = seg_q;
  assign cnt_out   = cnt_q;
  assign bus_err   = err_q;

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Self-checking bench for mio_bus_ctrl: vector table plus multi-cycle sequences.
module tb_mio_bus_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        mem_r, mem_w;
  logic [31:0] addr_in, wdata_in, rdata_out;
  logic        MIO_ready;
  logic [9:0]  ram_addr;
  logic [31:0] ram_din, ram_dout;
  logic        ram_we;
  logic [15:0] sw, led_out;
  logic [3:0]  btn;
  logic [31:0] seg_out, cnt_out;
  logic        bus_err;

  logic        mem_r3, mem_w3;
  logic [31:0] addr3, wdata3, rdata3;
  logic        ready3;
  logic [9:0]  ram_addr3;
  logic [31:0] ram_din3, ram_dout3;
  logic        ram_we3;
  logic [15:0] led3;
  logic [31:0] seg3, cnt3;
  logic        err3;

  mio_bus_ctrl #(.RAM_ADDR_W(10), .RAM_WAIT(1), .CNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .mem_r(mem_r), .mem_w(mem_w),
    .addr_in(addr_in), .wdata_in(wdata_in), .rdata_out(rdata_out),
    .MIO_ready(MIO_ready), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_we(ram_we), .ram_dout(ram_dout), .sw(sw), .btn(btn),
    .led_out(led_out), .seg_out(seg_out), .cnt_out(cnt_out), .bus_err(bus_err)
  );

  mio_bus_ctrl #(.RAM_ADDR_W(10), .RAM_WAIT(3), .CNT_W(32)) u_dut3 (
    .clk(clk), .reset(reset), .mem_r(mem_r3), .mem_w(mem_w3),
    .addr_in(addr3), .wdata_in(wdata3), .rdata_out(rdata3),
    .MIO_ready(ready3), .ram_addr(ram_addr3), .ram_din(ram_din3),
    .ram_we(ram_we3), .ram_dout(ram_dout3), .sw(sw), .btn(btn),
    .led_out(led3), .seg_out(seg3), .cnt_out(cnt3), .bus_err(err3)
  );

  // Synchronous RAM models: data valid one cycle after the address.
  logic [31:0] ram1 [1024];
  logic [31:0] ram3 [1024];
  always @(posedge clk) begin
    if (ram_we) ram1[ram_addr] <= ram_din;
    ram_dout <= ram1[ram_addr];
  end
  always @(posedge clk) begin
    if (ram_we3) ram3[ram_addr3] <= ram_din3;
    ram_dout3 <= ram3[ram_addr3];
  end

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q [$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Counter continuity monitor: each cycle must be previous+1 unless a load is expected.
  logic [31:0] prev_cnt;
  bit          prev_valid = 1'b0;
  bit          allow_jump = 1'b0;
  int          cnt_skips  = 0;
  always @(negedge clk) begin
    if (reset === 1'b1 && prev_valid && !allow_jump && cnt_out !== prev_cnt + 32'd1)
      cnt_skips++;
    prev_cnt   = cnt_out;
    prev_valid = (reset === 1'b1);
  end

  // One access on the RAM_WAIT=1 instance; scoreboard pushes on drive, pops on ready.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input int exp_lat, input logic [31:0] exp_rd,
                        input string nm, output int we_n, output logic [31:0] we_a);
    int          lat  = 0;
    bit          seen = 1'b0;
    logic [31:0] exp;
    we_n = 0;
    we_a = 32'd0;
    @(negedge clk);
    if (rd) exp_q.push_back(exp_rd);
    mem_r = rd; mem_w = wr; addr_in = a; wdata_in = d;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (ram_we) begin we_n++; we_a = 32'(ram_addr); end
      if (MIO_ready) seen = 1'b1;
    end
    mem_r = 1'b0; mem_w = 1'b0;
    check({nm, "_ready"}, 32'(seen), 32'd1);
    check({nm, "_lat"}, 32'(lat), 32'(exp_lat));
    if (rd) begin
      exp = exp_q.pop_front();
      check({nm, "_rdata"}, rdata_out, exp);
    end
  endtask

  typedef struct {
    logic        rd, wr;
    logic [31:0] addr, wdata;
    logic [15:0] sw;
    logic [3:0]  btn;
    logic [31:0] rdata;
    int          lat;
    logic [15:0] led;
    logic [31:0] seg;
    logic        err;
    int          we;
  } vec_t;

  function automatic vec_t mk(logic rd, logic wr, logic [31:0] a, logic [31:0] d,
                              logic [15:0] s, logic [3:0] b, logic [31:0] r, int lat,
                              logic [15:0] led, logic [31:0] seg, logic err, int we);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = a; v.wdata = d; v.sw = s; v.btn = b;
    v.rdata = r; v.lat = lat; v.led = led; v.seg = seg; v.err = err; v.we = we;
    return v;
  endfunction

  vec_t vecs [14];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          we_n;
    logic [31:0] we_a;
    int          n_rdy, n_we;
    int          rt [$];

    for (int i = 0; i < 1024; i++) begin ram1[i] = 32'd0; ram3[i] = 32'd0; end
    ram3[2] = 32'h0BAD_F00D;
    reset = 1'b0; mem_r = 1'b0; mem_w = 1'b0; addr_in = 32'd0; wdata_in = 32'd0;
    mem_r3 = 1'b0; mem_w3 = 1'b0; addr3 = 32'd0; wdata3 = 32'd0;
    sw = 16'd0; btn = 4'd0;

    //            rd    wr    addr          wdata         sw       btn   rdata        lat led      seg           err  we
    vecs[0]  = mk(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 16'h0,   4'h0, 32'h0,        1, 16'h0,    32'h0,        1'b0, 1);
    vecs[1]  = mk(1'b1, 1'b0, 32'h0000_0010, 32'h0,         16'h0,   4'h0, 32'hDEAD_BEEF, 2, 16'h0,    32'h0,        1'b0, 0);
    vecs[2]  = mk(1'b0, 1'b1, 32'h0000_0FFC, 32'h1357_9BDF, 16'h0,   4'h0, 32'h0,        1, 16'h0,    32'h0,        1'b0, 1);
    vecs[3]  = mk(1'b1, 1'b0, 32'h0000_0FFC, 32'h0,         16'h0,   4'h0, 32'h1357_9BDF, 2, 16'h0,    32'h0,        1'b0, 0);
    vecs[4]  = mk(1'b1, 1'b0, 32'h0000_0010, 32'h0,         16'h0,   4'h0, 32'hDEAD_BEEF, 2, 16'h0,    32'h0,        1'b0, 0);
    vecs[5]  = mk(1'b1, 1'b0, 32'hF000_0000, 32'h0,         16'hA5A5, 4'h9, 32'h9000_A5A5, 1, 16'h0,   32'h0,        1'b0, 0);
    vecs[6]  = mk(1'b0, 1'b1, 32'hF000_0000, 32'h0001_1234, 16'hA5A5, 4'h9, 32'h0,       1, 16'h1234, 32'h0,        1'b0, 0);
    vecs[7]  = mk(1'b0, 1'b1, 32'hE000_0000, 32'hCAFE_F00D, 16'h0,   4'h0, 32'h0,        1, 16'h1234, 32'hCAFE_F00D, 1'b0, 0);
    vecs[8]  = mk(1'b1, 1'b0, 32'hE000_0000, 32'h0,         16'h0,   4'h0, 32'hCAFE_F00D, 1, 16'h1234, 32'hCAFE_F00D, 1'b0, 0);
    vecs[9]  = mk(1'b1, 1'b0, 32'hE000_0003, 32'h0,         16'h0,   4'h0, 32'hCAFE_F00D, 1, 16'h1234, 32'hCAFE_F00D, 1'b0, 0);
    vecs[10] = mk(1'b1, 1'b0, 32'hF000_0000, 32'h0,         16'h0001, 4'h0, 32'h0000_0001, 1, 16'h1234, 32'hCAFE_F00D, 1'b0, 0);
    vecs[11] = mk(1'b1, 1'b0, 32'h1234_5678, 32'h0,         16'h0,   4'h0, 32'h0,        1, 16'h1234, 32'hCAFE_F00D, 1'b1, 0);
    vecs[12] = mk(1'b0, 1'b1, 32'h0000_1000, 32'h1111_1111, 16'h0,   4'h0, 32'h0,        1, 16'h1234, 32'hCAFE_F00D, 1'b1, 0);
    vecs[13] = mk(1'b1, 1'b0, 32'h0000_0000, 32'h0,         16'h0,   4'h0, 32'h0,        2, 16'h1234, 32'hCAFE_F00D, 1'b1, 0);

    // Power-on reset values.
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(MIO_ready), 32'd0);
    check("rst_we", 32'(ram_we), 32'd0);
    check("rst_rdata", rdata_out, 32'd0);
    check("rst_led", 32'(led_out), 32'd0);
    check("rst_seg", seg_out, 32'd0);
    check("rst_cnt", cnt_out, 32'd0);
    check("rst_err", 32'(bus_err), 32'd0);
    reset = 1'b1;

    // Vector table.
    for (int i = 0; i < 14; i++) begin
      sw = vecs[i].sw; btn = vecs[i].btn;
      access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].lat,
             vecs[i].rdata, $sformatf("v%0d", i), we_n, we_a);
      check($sformatf("v%0d_led", i), 32'(led_out), 32'(vecs[i].led));
      check($sformatf("v%0d_seg", i), seg_out, vecs[i].seg);
      check($sformatf("v%0d_err", i), 32'(bus_err), 32'(vecs[i].err));
      check($sformatf("v%0d_we_n", i), 32'(we_n), 32'(vecs[i].we));
      if (vecs[i].we == 1)
        check($sformatf("v%0d_we_addr", i), we_a, (vecs[i].addr >> 2) & 32'h3FF);
    end

    // Counter load, wrap and sampled read.
    allow_jump = 1'b1;
    access(1'b0, 1'b1, 32'hF000_0004, 32'hFFFF_FFFE, 1, 32'd0, "cnt_wr", we_n, we_a);
    check("cnt_loaded", cnt_out, 32'hFFFF_FFFE);
    @(negedge clk);
    allow_jump = 1'b0;
    @(negedge clk);
    check("cnt_wrapped", cnt_out, 32'h0000_0000);
    access(1'b1, 1'b0, 32'hF000_0004, 32'd0, 1, 32'h0000_0001, "cnt_rd", we_n, we_a);

    // Illegal both-high request is ignored.
    @(negedge clk);
    mem_r = 1'b1; mem_w = 1'b1; addr_in = 32'hF000_0000; wdata_in = 32'h0000_FFFF;
    n_rdy = 0; n_we = 0;
    repeat (5) begin
      @(negedge clk);
      if (MIO_ready) n_rdy++;
      if (ram_we) n_we++;
    end
    mem_r = 1'b0; mem_w = 1'b0;
    check("both_ready", 32'(n_rdy), 32'd0);
    check("both_we", 32'(n_we), 32'd0);
    check("both_led", 32'(led_out), 32'h0000_1234);
    check("err_sticky", 32'(bus_err), 32'd1);
    access(1'b1, 1'b0, 32'h0000_0010, 32'd0, 2, 32'hDEAD_BEEF, "ram_reread", we_n, we_a);

    // Back-to-back RAM reads on the RAM_WAIT=3 instance with mem_r held.
    @(negedge clk);
    mem_r3 = 1'b1; addr3 = 32'h0000_0008;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (ready3) begin
        rt.push_back(k);
        check("t6_rdata", rdata3, 32'h0BAD_F00D);
      end
    end
    mem_r3 = 1'b0;
    check("t6_count", 32'(rt.size()), 32'd4);
    if (rt.size() > 0) check("t6_first", 32'(rt[0]), 32'd4);
    for (int i = 1; i < rt.size(); i++)
      check($sformatf("t6_gap%0d", i), 32'(rt[i] - rt[i-1]), 32'd5);

    // Reset held three cycles while a RAM read sits in WAIT.
    repeat (8) @(negedge clk);
    mem_r = 1'b1; addr_in = 32'h0000_0010;
    @(negedge clk);
    check("mid_wait_ready", 32'(MIO_ready), 32'd0);
    reset = 1'b0; mem_r = 1'b0;
    n_rdy = 0; n_we = 0;
    repeat (3) begin
      @(negedge clk);
      if (MIO_ready) n_rdy++;
      if (ram_we) n_we++;
    end
    check("rr_rdata", rdata_out, 32'd0);
    check("rr_led", 32'(led_out), 32'd0);
    check("rr_seg", seg_out, 32'd0);
    check("rr_cnt", cnt_out, 32'd0);
    check("rr_err", 32'(bus_err), 32'd0);
    reset = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (MIO_ready) n_rdy++;
      if (ram_we) n_we++;
    end
    check("rr_no_ready", 32'(n_rdy), 32'd0);
    check("rr_no_we", 32'(n_we), 32'd0);

    check("cnt_no_skip", 32'(cnt_skips), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mio_bus_ctrl.md
Name: mio_bus_ctrl

Overview:
Memory/IO bus controller directly downstream of the multi-cycle CPU top. It consumes the CPU's Addr_out/Data_out/mem_w/mem_r and returns read data plus the MIO_ready handshake. It decodes each access to one of four targets:
- external synchronous block RAM;
- LED/switch GPIO;
- 7-segment display register;
- a free-running 32-bit counter.

Every access completes with exactly one MIO_ready pulse, so the CPU never hangs.

Parameters:
- RAM_ADDR_W, 10: word-address width of data RAM (RAM spans 4*2^RAM_ADDR_W bytes from 0x0000_0000).
- RAM_WAIT, 1: wait cycles between RAM read accept and response; legal range 1..7.
- CNT_W, 32: counter width, ≤32, zero-extended on read.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- mem_r  in  1  CPU read request.
- mem_w  in  1  CPU write request.
- addr_in  in  32  CPU byte address; bits [1:0] ignored.
- wdata_in  in  32  CPU write data.
- rdata_out  out  32  read data to CPU Data_in.
- MIO_ready  out  1  one-cycle access-complete pulse.
- ram_addr  out  RAM_ADDR_W  RAM word address.
- ram_din  out  32  RAM write data.
- ram_we  out  1  RAM write strobe.
- ram_dout  in  32  RAM read data, valid one cycle after ram_addr.
- sw  in  16  switches.
- btn  in  4  buttons.
- led_out  out  16  LED register.
- seg_out  out  32  7-segment display register.
- cnt_out  out  CNT_W  counter value.
- bus_err  out  1  sticky flag set on any unmapped access.

Behaviour:
Reset (reset==0 at a clock edge):
- state=IDLE.
- MIO_ready, ram_we, bus_err = 0.
- led_out, seg_out, cnt_out, rdata_out = 0.
- Latched address and data cleared.
- Reset wins over any in-flight access; an aborted write is not performed.

Address map (full 32-bit compare, addr_in[1:0] ignored):
- RAM: addr_in[31:RAM_ADDR_W+2]==0; ram_addr = addr_in[RAM_ADDR_W+1:2].
- 0xE000_0000: seg register, R/W.
- 0xF000_0000: read returns {btn, 12'b0, sw}; write loads led_out from wdata[15:0].
- 0xF000_0004: counter, R/W.
- Any other address is unmapped: read returns 0, write is dropped, bus_err is set, and the access still completes normally.

States: IDLE, WAIT, RESP.
- MIO_ready is 1 only in RESP (registered).
- Requests are sampled only in IDLE. mem_r and mem_w must be held stable until MIO_ready is seen.
- IDLE, mem_r^mem_w==1: latch addr_in, wdata_in and the decoded target.
  - RAM read → WAIT, with wait counter loaded to RAM_WAIT-1.
  - Any other read, or any write → RESP.
- IDLE with mem_r&mem_w==1, or both 0: stay in IDLE; the illegal both-high case is ignored.
- WAIT: ram_addr driven from the latch. Counter==0 → RESP, else decrement.
- RESP: MIO_ready=1 for exactly one cycle, then unconditionally → IDLE. A request still asserted in the following IDLE is treated as a new access.

Timing (accept edge at cycle t):
- Register read: rdata_out valid and MIO_ready=1 at t+1.
- RAM read: MIO_ready=1 at t+RAM_WAIT+1. rdata_out is captured from ram_dout on the edge entering RESP.
- Write: peripheral register updated on the accept edge. For RAM, ram_we=1 exactly during RESP, with latched ram_addr and ram_din. MIO_ready=1 at t+1.

rdata_out holds its last response value outside RESP.

Counter:
- Increments every cycle and wraps at 2^CNT_W-1 → 0.
- A CPU write loads wdata[CNT_W-1:0] on the accept edge; the load wins over the increment that cycle.
- A read returns the value sampled at the accept edge.

bus_err: cleared only by reset.

Decomposition:
- Shared package mio_pkg holds:
  - state encoding (IDLE/WAIT/RESP);
  - target enum (T_RAM, T_SEG, T_GPIO, T_CNT, T_NONE);
  - address constants SEG_ADDR=0xE000_0000, GPIO_ADDR=0xF000_0000, CNT_ADDR=0xF000_0004.
- One sub-module, mio_addr_decode: combinational addr → target plus RAM-range check. The FSM, registers and counter stay in the top level.

Test Plan:
1. Reset held 3 cycles mid-RAM-read (in WAIT) → MIO_ready=0, ram_we=0, all registers 0, state IDLE; no spurious ready after release.
2. mem_w to 0x0000_0010 with data 0xDEADBEEF, then mem_r to the same address (RAM_WAIT=1) → ram_we pulses once with ram_addr=4; read MIO_ready rises exactly 2 cycles after accept; rdata_out=0xDEADBEEF.
3. sw=0xA5A5, btn=0x9, read 0xF000_0000 → rdata_out=0x9000_A5A5 with MIO_ready at t+1. Write 0x0001_1234 to the same address → led_out=0x1234.
4. Write 0xFFFF_FFFE to 0xF000_0004, let 3 cycles elapse, read it → value has wrapped past 0 (e.g. 0x0000_0001 at accept); cnt_out never skips a value except at the load.
5. Read 0x1234_5678 (unmapped) → rdata_out=0, MIO_ready pulses at t+1, bus_err=1 and stays set. mem_r=mem_w=1 for 5 cycles → no MIO_ready, no writes.
6. RAM_WAIT=3, back-to-back reads with mem_r held through the RESP cycle → exactly one ready per access; successive readies are 5 cycles apart (accept, 3 WAIT, RESP).
